sdram_bus_bridge: RTL and testbench
===================================

# sdram_bus_bridge

Bridges the 32-bit PicoRV32 native memory bus to the 16-bit host interface of `sdram_controller`. It sits between the SoC address decoder (SDRAM window 0x0400_0000) and the controller. Each CPU word access is split into two halfword SDRAM commands. Byte-strobed writes are handled with read-modify-write so that untouched bytes are preserved. It returns a single-cycle `mem_ready` with full 32-bit read data, replacing the zero-extended 16-bit path.

## Interface
- `ADDR_WIDTH`, default 22: halfword address width on the controller side. The word address is taken from `mem_addr[ADDR_WIDTH:2]`.
- `clk_sys`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sel`  in  1  `mem_valid && is_sdram` from the decoder.
- `mem_addr`  in  32  CPU byte address.
- `mem_wdata`  in  32  CPU write data.
- `mem_wstrb`  in  4  byte strobes; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data; valid while `mem_ready`=1.
- `sd_wr_addr`  out  ADDR_WIDTH  controller write halfword address.
- `sd_wr_data`  out  16  controller write data.
- `sd_wr_enable`  out  1  write request.
- `sd_rd_addr`  out  ADDR_WIDTH  controller read halfword address.
- `sd_rd_enable`  out  1  read request.
- `sd_rd_data`  in  16  controller read data.
- `sd_rd_ready`  in  1  read data valid pulse.
- `sd_busy`  in  1  controller busy; a request is accepted only when 0.

## Operation
- Halfword mapping is little-endian.
  - Half 0: address `{mem_addr[ADDR_WIDTH:2],0}`, carries bytes [15:0].
  - Half 1: address `{mem_addr[ADDR_WIDTH:2],1}`, carries bytes [31:16].
  - `mem_addr[1:0]` is ignored.
- Per-half action, decided at IDLE:
  - Read (`wstrb`=0): read both halves.
  - Both strobes of a half set: direct write.
  - Exactly one strobe of a half set: read, merge the strobed byte from `mem_wdata`, write.
  - No strobes for a half: skip it.
- The bridge latches `mem_addr`, `mem_wdata` and `mem_wstrb` in IDLE on `sel`=1. It processes half 0, then half 1.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
  - IDLE: on `sel`=1, latch the request and go to the first needed half's first state.
  - RD_ISSUE: `sd_rd_enable` = !`sd_busy`. Go to RD_WAIT on the cycle the request is accepted.
  - RD_WAIT: on `sd_rd_ready`, store `sd_rd_data` into the half buffer. Then:
    - if the half needs a merge, go to WR_ISSUE;
    - otherwise go to the next half, or to DONE.
  - WR_ISSUE: `sd_wr_enable` = !`sd_busy`, with `sd_wr_data` = merged halfword. Go to WR_WAIT on acceptance.
  - WR_WAIT: ignore `sd_busy` for the first cycle (busy rises one cycle after acceptance). Then wait for `sd_busy`=0, and go to the next half or to DONE.
  - DONE: `mem_ready`=1 and `mem_rdata` = {buf1,buf0}. Go unconditionally to IDLE.
- Enables are asserted for exactly one accepted cycle per command. Both enables are never high together.
- Write-only transactions return `mem_rdata`=0.
- If `sel` drops mid-transaction, the already-accepted SDRAM command completes. The FSM returns to IDLE without pulsing `mem_ready`.
- On `reset_n`=0 at any time (including RD_WAIT/WR_WAIT):
  - state returns to IDLE immediately;
  - all outputs and buffers are cleared to 0;
  - any in-flight `sd_rd_ready` is ignored.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `sd_*_enable`=0, `sd_wr_addr`=`sd_rd_addr`=0, `sd_wr_data`=0.
- Latency from `sel` rising to `mem_ready`, with controller read latency R (accept to `sd_rd_ready`) and write busy time W:
  - full read: 1 + 2·(1+R) + 1;
  - full write: 1 + 2·(1+1+W) + 1;
  - each merged half adds one read plus one write.
- Each ISSUE state stalls while `sd_busy`=1 (refresh), with no upper bound.
- `mem_ready` is high for exactly one cycle. The CPU drops `sel` the following cycle, so the IDLE after DONE never re-triggers on the same request.

## Test plan
- Full write of 0x12345678 with `wstrb`=1111 to 0x0400_0010 gives:
  - writes of hw 0x08 = 0x5678 and hw 0x09 = 0x1234;
  - no reads;
  - one `mem_ready`.
  
  Reading the same address then returns 0x12345678.
- After the full write, write `wstrb`=0010 with `wdata`=0x0000AB00:
  - read hw 0x08 returns 0x5678;
  - write hw 0x08 = 0xAB78;
  - hw 0x09 is not accessed;
  - a later read returns 0x1234AB78.
- `wstrb`=1100 with `wdata`=0xCAFE0000 produces a single write, hw 0x09 = 0xCAFE, with no read commands.
- Hold `sd_busy`=1 for 20 cycles while `sel` is asserted:
  - no enable is asserted and no `mem_ready` occurs during the stall;
  - the request is issued the first cycle busy is low;
  - the data is correct.
- Pulse `reset_n` low during RD_WAIT:
  - outputs are 0 that same cycle;
  - a stray `sd_rd_ready` after release is ignored;
  - the next read completes correctly.
- Two back-to-back reads at different words each produce exactly one `mem_ready` with the correct {hi,lo} data, and never more than one outstanding SDRAM command.

Source files
------------

// File: rtl/sdram_bus_bridge.sv
// Bridges the 32-bit PicoRV32 native bus to the 16-bit sdram_controller host port.
// Each CPU word becomes up to two halfword commands; partial halves use read-modify-write.
module sdram_bus_bridge #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  sel,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] sd_wr_addr,
  output logic [15:0]           sd_wr_data,
  output logic                  sd_wr_enable,
  output logic [ADDR_WIDTH-1:0] sd_rd_addr,
  output logic                  sd_rd_enable,
  input  logic [15:0]           sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACT_SKIP, ACT_READ, ACT_WRITE, ACT_MERGE
  } act_t;

  // A zero strobe word is a read of both halves; otherwise each half is judged on its own strobes.
  function automatic act_t half_action(input logic [3:0] strb, input logic half);
    logic [1:0] s;
    s = half ? strb[3:2] : strb[1:0];
    if (strb == 4'b0000) return ACT_READ;
    case (s)
      2'b11:   return ACT_WRITE;
      2'b00:   return ACT_SKIP;
      default: return ACT_MERGE;
    endcase
  endfunction

  function automatic state_t first_state(input act_t act);
    return (act == ACT_WRITE) ? S_WR_ISSUE : S_RD_ISSUE;
  endfunction

  state_t                state_q, state_d;
  logic                  half_q, half_d;
  logic [ADDR_WIDTH-2:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [15:0]           buf0_q, buf0_d;
  logic [15:0]           buf1_q, buf1_d;
  logic                  wr_first_q, wr_first_d;

  act_t        act_cur, act_hi, act_in0, act_in1;
  logic [15:0] cur_buf, cur_wd;
  logic [1:0]  cur_st;

  // Address bits outside the SDRAM window and the byte offset are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+1], mem_addr[1:0]};

  assign act_cur = half_action(wstrb_q, half_q);
  assign act_hi  = half_action(wstrb_q, 1'b1);
  assign act_in0 = half_action(mem_wstrb, 1'b0);
  assign act_in1 = half_action(mem_wstrb, 1'b1);

  assign cur_buf = half_q ? buf1_q : buf0_q;
  assign cur_wd  = half_q ? wdata_q[31:16] : wdata_q[15:0];
  assign cur_st  = half_q ? wstrb_q[3:2] : wstrb_q[1:0];

  // Strobed bytes come from the CPU, the rest from the halfword just read back.
  assign sd_wr_data = {cur_st[1] ? cur_wd[15:8] : cur_buf[15:8],
                       cur_st[0] ? cur_wd[7:0]  : cur_buf[7:0]};
  assign sd_wr_addr = {word_q, half_q};
  assign sd_rd_addr = {word_q, half_q};

  // NOTE: async active-low reset; every register, including the data buffers, is
  // cleared so combinational outputs derived from them read 0 while reset is held.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      half_q     <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      wr_first_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates appear simultaneously at the edge.
      state_q    <= state_d;
      half_q     <= half_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      wr_first_q <= wr_first_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    half_d       = half_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    wr_first_d   = wr_first_q;
    sd_rd_enable = 1'b0;
    sd_wr_enable = 1'b0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          word_d  = mem_addr[ADDR_WIDTH:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          buf0_d  = '0;
          buf1_d  = '0;
          if (act_in0 != ACT_SKIP) begin
            half_d  = 1'b0;
            state_d = first_state(act_in0);
          end else begin
            half_d  = 1'b1;
            state_d = first_state(act_in1);
          end
        end
      end

      S_RD_ISSUE: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (!sd_busy) begin
          sd_rd_enable = 1'b1;
          state_d      = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // The accepted read always runs to completion, even if the CPU has gone away.
        if (sd_rd_ready) begin
          if (half_q) buf1_d = sd_rd_data;
          else        buf0_d = sd_rd_data;
          if (!sel) begin
            state_d = S_IDLE;
          end else if (act_cur == ACT_MERGE) begin
            state_d = S_WR_ISSUE;
          end else if (!half_q && act_hi != ACT_SKIP) begin
            half_d  = 1'b1;
            state_d = first_state(act_hi);
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_WR_ISSUE: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (!sd_busy) begin
          sd_wr_enable = 1'b1;
          wr_first_d   = 1'b1;
          state_d      = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        // The controller raises busy one cycle after acceptance, so the first cycle is blind.
        wr_first_d = 1'b0;
        if (!wr_first_q && !sd_busy) begin
          if (!sel) begin
            state_d = S_IDLE;
          end else if (!half_q && act_hi != ACT_SKIP) begin
            half_d  = 1'b1;
            state_d = first_state(act_hi);
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        mem_ready = 1'b1;
        if (wstrb_q == 4'b0000) mem_rdata = {buf1_q, buf0_q};
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Directed bench for sdram_bus_bridge with a small behavioural SDRAM controller model.
module tb_sdram_bus_bridge;

  localparam int AW = 22;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          sel = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] sd_wr_addr;
  logic [15:0]   sd_wr_data;
  logic          sd_wr_enable;
  logic [AW-1:0] sd_rd_addr;
  logic          sd_rd_enable;
  logic [15:0]   sd_rd_data = '0;
  logic          sd_rd_ready = 1'b0;
  logic          sd_busy;

  sdram_bus_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sel(sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller model: reads return after rd_lat cycles, writes hold busy for 2 cycles.
  logic        force_busy = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rd_lat = 3;
  logic [5:0]  rd_a = '0;
  logic [15:0] sdmem [0:63];

  assign sd_busy = force_busy || (wr_cnt != 0);

  always @(posedge clk_sys) begin
    sd_rd_ready <= 1'b0;
    if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) begin
        sd_rd_ready <= 1'b1;
        sd_rd_data  <= sdmem[rd_a];
      end
    end else if (sd_rd_enable && !sd_busy) begin
      rd_cnt <= rd_lat;
      rd_a   <= sd_rd_addr[5:0];
    end
    if (wr_cnt != 0) begin
      wr_cnt <= wr_cnt - 1;
    end else if (sd_wr_enable && !sd_busy) begin
      sdmem[sd_wr_addr[5:0]] = sd_wr_data;
      wr_cnt <= 2;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int            n_rd = 0, n_wr = 0, n_ready = 0, proto_err = 0;
  logic          out_rd = 1'b0;
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wr_alog [$];
  logic [15:0]   wr_dlog [$];

  always @(negedge clk_sys) begin
    if (sd_rd_enable && sd_wr_enable) proto_err++;
    if (sd_rd_ready) out_rd = 1'b0;
    if (sd_rd_enable && !sd_busy) begin
      if (out_rd) proto_err++;
      out_rd = 1'b1;
      n_rd++;
      rd_log.push_back(sd_rd_addr);
    end
    if (sd_wr_enable && !sd_busy) begin
      if (out_rd) proto_err++;
      n_wr++;
      wr_alog.push_back(sd_wr_addr);
      wr_dlog.push_back(sd_wr_data);
    end
    if (mem_ready) n_ready++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int b_rd, b_wr, b_rdy;

  task automatic snap();
    b_rd  = n_rd;
    b_wr  = n_wr;
    b_rdy = n_ready;
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    rd = 'x;
    @(negedge clk_sys);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; sel = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (mem_ready) begin
        ok = 1'b1;
        rd = mem_rdata;
        break;
      end
    end
    sel = 1'b0;
    mem_wstrb = '0;
    @(negedge clk_sys);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL txn_timeout addr=%h: mem_ready never seen, required within 300 cycles", a);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({mem_ready, mem_rdata, sd_rd_enable, sd_wr_enable} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b rdata=%h rde=%b wre=%b, required all 0",
               mem_ready, mem_rdata, sd_rd_enable, sd_wr_enable);
    end
    n_cmp++;
    if ({sd_rd_addr, sd_wr_addr, sd_wr_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: rd_addr=%h wr_addr=%h wr_data=%h, required 0",
               sd_rd_addr, sd_wr_addr, sd_wr_data);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_full_write();
    logic [31:0] r;
    snap();
    wr_alog.delete(); wr_dlog.delete();
    do_txn(32'h0400_0010, 32'h1234_5678, 4'b1111, r);
    n_cmp++;
    if (n_rd - b_rd !== 0 || n_wr - b_wr !== 2 || n_ready - b_rdy !== 1) begin
      n_bad++;
      $display("FAIL full_write_counts: rd=%0d wr=%0d ready=%0d, required 0 2 1",
               n_rd - b_rd, n_wr - b_wr, n_ready - b_rdy);
    end
    n_cmp++;
    if (wr_alog.size() != 2 || wr_alog[0] !== 22'h08 || wr_dlog[0] !== 16'h5678 ||
        wr_alog[1] !== 22'h09 || wr_dlog[1] !== 16'h1234) begin
      n_bad++;
      $display("FAIL full_write_cmds: n=%0d first=%h:%h second=%h:%h, required 08:5678 09:1234",
               wr_alog.size(), wr_alog[0], wr_dlog[0], wr_alog[1], wr_dlog[1]);
    end
    n_cmp++;
    if (r !== 32'h0) begin
      n_bad++;
      $display("FAIL full_write_rdata: got %h, required 00000000", r);
    end
    snap();
    rd_log.delete();
    do_txn(32'h0400_0010, 32'h0, 4'b0000, r);
    n_cmp++;
    if (r !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL full_read_data: got %h, required 12345678", r);
    end
    n_cmp++;
    if (n_wr - b_wr !== 0 || rd_log.size() != 2 || rd_log[0] !== 22'h08 || rd_log[1] !== 22'h09) begin
      n_bad++;
      $display("FAIL full_read_cmds: wr=%0d nrd=%0d order=%h,%h, required 0 2 08,09",
               n_wr - b_wr, rd_log.size(), rd_log[0], rd_log[1]);
    end
  endtask

  task automatic test_merge_write();
    logic [31:0] r;
    snap();
    rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
    do_txn(32'h0400_0010, 32'h0000_AB00, 4'b0010, r);
    n_cmp++;
    if (rd_log.size() != 1 || rd_log[0] !== 22'h08) begin
      n_bad++;
      $display("FAIL merge_read: nrd=%0d addr=%h, required 1 at 08", rd_log.size(), rd_log[0]);
    end
    n_cmp++;
    if (wr_alog.size() != 1 || wr_alog[0] !== 22'h08 || wr_dlog[0] !== 16'hAB78) begin
      n_bad++;
      $display("FAIL merge_write: nwr=%0d cmd=%h:%h, required 1 at 08:AB78",
               wr_alog.size(), wr_alog[0], wr_dlog[0]);
    end
    n_cmp++;
    if (r !== 32'h0 || n_ready - b_rdy !== 1) begin
      n_bad++;
      $display("FAIL merge_ready: rdata=%h ready=%0d, required 00000000 1", r, n_ready - b_rdy);
    end
    do_txn(32'h0400_0010, 32'h0, 4'b0000, r);
    n_cmp++;
    if (r !== 32'h1234_AB78) begin
      n_bad++;
      $display("FAIL merge_readback: got %h, required 1234AB78", r);
    end
  endtask

  task automatic test_upper_write();
    logic [31:0] r;
    snap();
    wr_alog.delete(); wr_dlog.delete();
    do_txn(32'h0400_0010, 32'hCAFE_0000, 4'b1100, r);
    n_cmp++;
    if (n_rd - b_rd !== 0 || wr_alog.size() != 1 || wr_alog[0] !== 22'h09 || wr_dlog[0] !== 16'hCAFE) begin
      n_bad++;
      $display("FAIL upper_write: rd=%0d nwr=%0d cmd=%h:%h, required 0 1 09:CAFE",
               n_rd - b_rd, wr_alog.size(), wr_alog[0], wr_dlog[0]);
    end
  endtask

  task automatic test_busy_stall();
    int viol;
    bit ok;
    logic [31:0] r;
    viol = 0;
    ok = 1'b0;
    r = 'x;
    snap();
    @(negedge clk_sys);
    force_busy = 1'b1;
    mem_addr = 32'h0400_0010; mem_wstrb = 4'b0000; sel = 1'b1;
    repeat (20) begin
      @(negedge clk_sys);
      if (sd_rd_enable || sd_wr_enable || mem_ready) viol++;
    end
    n_cmp++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL stall_quiet: %0d cycles with activity during busy, required 0", viol);
    end
    force_busy = 1'b0;
    #1;
    n_cmp++;
    if (sd_rd_enable !== 1'b1 || sd_rd_addr !== 22'h08) begin
      n_bad++;
      $display("FAIL stall_issue: rd_en=%b addr=%h on first idle cycle, required 1 08",
               sd_rd_enable, sd_rd_addr);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (mem_ready) begin
        ok = 1'b1;
        r = mem_rdata;
        break;
      end
    end
    sel = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if (!ok || r !== 32'hCAFE_AB78 || n_ready - b_rdy !== 1) begin
      n_bad++;
      $display("FAIL stall_data: done=%b rdata=%h ready=%0d, required 1 CAFEAB78 1",
               ok, r, n_ready - b_rdy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [31:0] r;
    seen = 1'b0;
    rd_lat = 6;
    @(negedge clk_sys);
    mem_addr = 32'h0400_0020; mem_wstrb = 4'b0000; sel = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (sd_rd_enable && !sd_busy) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL rstmid_issue: read never issued, required within 50 cycles");
    end
    @(negedge clk_sys);
    reset_n = 1'b0;
    sel = 1'b0;
    #1;
    n_cmp++;
    if ({mem_ready, mem_rdata, sd_rd_enable, sd_wr_enable, sd_rd_addr, sd_wr_addr, sd_wr_data} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: ready=%b rdata=%h rde=%b wre=%b rda=%h wra=%h wrd=%h, required all 0",
               mem_ready, mem_rdata, sd_rd_enable, sd_wr_enable, sd_rd_addr, sd_wr_addr, sd_wr_data);
    end
    snap();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    n_cmp++;
    if (n_ready - b_rdy !== 0 || n_rd - b_rd !== 0 || mem_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_stray: ready=%0d reads=%0d rdata=%h, required 0 0 00000000",
               n_ready - b_rdy, n_rd - b_rd, mem_rdata);
    end
    rd_lat = 3;
    do_txn(32'h0400_0020, 32'h0, 4'b0000, r);
    n_cmp++;
    if (r !== 32'h2222_1111) begin
      n_bad++;
      $display("FAIL rstmid_next: got %h, required 22221111", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, r1;
    int rdy0;
    snap();
    rd_log.delete();
    do_txn(32'h0400_0020, 32'h0, 4'b0000, r0);
    rdy0 = n_ready - b_rdy;
    do_txn(32'h0400_0024, 32'h0, 4'b0000, r1);
    n_cmp++;
    if (r0 !== 32'h2222_1111 || r1 !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL b2b_data: got %h %h, required 22221111 DEADBEEF", r0, r1);
    end
    n_cmp++;
    if (rdy0 !== 1 || n_ready - b_rdy !== 2) begin
      n_bad++;
      $display("FAIL b2b_ready: first=%0d total=%0d, required 1 2", rdy0, n_ready - b_rdy);
    end
    n_cmp++;
    if (rd_log.size() != 4 || rd_log[2] !== 22'h12 || rd_log[3] !== 22'h13) begin
      n_bad++;
      $display("FAIL b2b_addr: nrd=%0d second=%h,%h, required 4 12,13",
               rd_log.size(), rd_log[2], rd_log[3]);
    end
    n_cmp++;
    if (proto_err !== 0) begin
      n_bad++;
      $display("FAIL protocol: %0d overlap/outstanding violations, required 0", proto_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sdmem[i] = 16'h0000;
    sdmem[6'h10] = 16'h1111;
    sdmem[6'h11] = 16'h2222;
    sdmem[6'h12] = 16'hBEEF;
    sdmem[6'h13] = 16'hDEAD;
    test_reset();
    test_full_write();
    test_merge_write();
    test_upper_write();
    test_busy_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
